// File: rtl/alu_seq.sv
// Sequential ALU: one op per valid/ready handshake, programmable single-step delay, shift-add multiply.
// Optional ALU_SEQ_FLAGS_EN adds flag_zero/flag_carry/flag_overflow outputs.
module alu_seq #(
  parameter int WIDTH      = 32,
  parameter int OP_WIDTH   = 8,
  parameter int DONE_DELAY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    operand_a,
  input  logic [WIDTH-1:0]    operand_b,
  input  logic [OP_WIDTH-1:0] operator,
  input  logic                op_valid,
  output logic                op_ready,
  output logic                operation_done,
  output logic [WIDTH-1:0]    result,
  output logic                op_error,
`ifdef ALU_SEQ_FLAGS_EN
  output logic                flag_zero,
  output logic                flag_carry,
  output logic                flag_overflow,
`endif
  output logic [1:0]          fsm_state
);

  // Handshake: a request transfers on a rising edge where op_valid && op_ready;
  // op_ready is high only in IDLE and nothing is sampled in any other state.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_SHL = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SHR = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(7);

  localparam int SW = $clog2(WIDTH);
  localparam int MW = $clog2(WIDTH);
  localparam int CW = (DONE_DELAY > 1) ? $clog2(DONE_DELAY) : 1;
`ifdef ALU_SEQ_FLAGS_EN
  // Full-width product is kept so discarded high bits can drive flag_carry.
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif

  logic [1:0]          state;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [OP_WIDTH-1:0] op_q;
  logic [CW-1:0]       exec_cnt;
  logic [PW-1:0]       mul_acc, mul_a, mul_sum;
  logic [WIDTH-1:0]    mul_b;
  logic [MW-1:0]       mul_cnt;
  logic [WIDTH-1:0]    exec_res;
  logic                exec_err;

  assign op_ready       = (state == S_IDLE);
  assign operation_done = (state == S_DONE);
  assign fsm_state      = state;

  always_comb begin
    exec_res = '0;
    exec_err = 1'b0;
    case (op_q)
      OP_ADD:  exec_res = a_q + b_q;
      OP_SUB:  exec_res = a_q - b_q;
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_SHL:  exec_res = a_q << b_q[SW-1:0];
      OP_SHR:  exec_res = a_q >> b_q[SW-1:0];
      default: exec_err = 1'b1;
    endcase
  end

  assign mul_sum = mul_acc + (mul_b[0] ? mul_a : '0);

`ifdef ALU_SEQ_FLAGS_EN
  logic [WIDTH:0] add_w, sub_w;
  logic           exec_c, exec_v;

  always_comb begin
    add_w  = {1'b0, a_q} + {1'b0, b_q};
    sub_w  = {1'b0, a_q} - {1'b0, b_q};
    exec_c = 1'b0;
    exec_v = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_c = add_w[WIDTH];
        exec_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        exec_c = sub_w[WIDTH];
        exec_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      default: ;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      exec_cnt <= '0;
      mul_acc  <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_cnt  <= '0;
      result   <= '0;
      op_error <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      flag_zero     <= 1'b0;
      flag_carry    <= 1'b0;
      flag_overflow <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (op_valid) begin
          a_q      <= operand_a;
          b_q      <= operand_b;
          op_q     <= operator;
          mul_acc  <= '0;
          mul_a    <= PW'(operand_a);
          mul_b    <= operand_b;
          mul_cnt  <= '0;
          exec_cnt <= CW'(DONE_DELAY - 1);
          state    <= (operator == OP_MUL) ? S_MUL : S_EXEC;
        end
        S_EXEC: if (exec_cnt == '0) begin
          result   <= exec_res;
          op_error <= exec_err;
`ifdef ALU_SEQ_FLAGS_EN
          flag_zero     <= (exec_res == '0);
          flag_carry    <= exec_c;
          flag_overflow <= exec_v;
`endif
          state    <= S_DONE;
        end else begin
          exec_cnt <= exec_cnt - 1'b1;
        end
        S_MUL: begin
          // One multiplier bit per cycle, LSB first; the last sum goes straight to result.
          mul_acc <= mul_sum;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          mul_cnt <= mul_cnt + 1'b1;
          if (mul_cnt == MW'(WIDTH - 1)) begin
            result   <= mul_sum[WIDTH-1:0];
            op_error <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            flag_zero     <= (mul_sum[WIDTH-1:0] == '0);
            flag_carry    <= |mul_sum[PW-1:WIDTH];
            flag_overflow <= 1'b0;
`endif
            state    <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: two instances (DONE_DELAY=1 and 4), directed cases plus random ops
// checked against an arithmetic reference model and an expected-result queue.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] operand_a[2];
  logic [31:0] operand_b[2];
  logic [7:0]  opcode[2];
  logic        op_valid[2];
  logic        op_ready[2];
  logic        operation_done[2];
  logic [31:0] result[2];
  logic        op_error[2];
  logic [1:0]  fsm_state[2];
`ifdef ALU_SEQ_FLAGS_EN
  logic        flag_zero[2], flag_carry[2], flag_overflow[2];
`endif

  int dd[2] = '{1, 4};
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .OP_WIDTH(8), .DONE_DELAY(1)) dut0 (
    .clk(clk), .reset(reset),
    .operand_a(operand_a[0]), .operand_b(operand_b[0]), .operator(opcode[0]),
    .op_valid(op_valid[0]), .op_ready(op_ready[0]), .operation_done(operation_done[0]),
    .result(result[0]), .op_error(op_error[0]),
`ifdef ALU_SEQ_FLAGS_EN
    .flag_zero(flag_zero[0]), .flag_carry(flag_carry[0]), .flag_overflow(flag_overflow[0]),
`endif
    .fsm_state(fsm_state[0])
  );

  alu_seq #(.WIDTH(32), .OP_WIDTH(8), .DONE_DELAY(4)) dut1 (
    .clk(clk), .reset(reset),
    .operand_a(operand_a[1]), .operand_b(operand_b[1]), .operator(opcode[1]),
    .op_valid(op_valid[1]), .op_ready(op_ready[1]), .operation_done(operation_done[1]),
    .result(result[1]), .op_error(op_error[1]),
`ifdef ALU_SEQ_FLAGS_EN
    .flag_zero(flag_zero[1]), .flag_carry(flag_carry[1]), .flag_overflow(flag_overflow[1]),
`endif
    .fsm_state(fsm_state[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on wide integers.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op,
                                output logic [31:0] r, output logic e,
                                output logic c, output logic v);
    longint unsigned wide;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'h0; e = 1'b0; c = 1'b0; v = 1'b0;
    case (op)
      8'h00: begin
        wide = longint'(a) + longint'(b);
        r = wide[31:0]; c = wide[32];
        s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      8'h01: begin
        r = a - b; c = (a < b);
        s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      8'h02: r = a & b;
      8'h03: r = a | b;
      8'h04: r = a ^ b;
      8'h05: r = a << b[4:0];
      8'h06: r = a >> b[4:0];
      8'h07: begin
        wide = {32'h0, a} * {32'h0, b};
        r = wide[31:0]; c = (wide[63:32] != 32'h0);
      end
      default: e = 1'b1;
    endcase
  endfunction

  task automatic do_op(input int s, input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
    logic [31:0] er, held;
    logic ee, ec, ev, seen;
    int n, busy_bad, lat_exp;
    model(a, b, op, er, ee, ec, ev);
    exp_q.push_back(er);
    n = 0;
    while (!op_ready[s] && n < 200) begin @(negedge clk); n++; end
    check("ready_wait", n < 200, 1);
    operand_a[s] = a; operand_b[s] = b; opcode[s] = op; op_valid[s] = 1'b1;
    @(posedge clk); #1;
    op_valid[s] = 1'b0;
    operand_a[s] = $urandom(); operand_b[s] = $urandom(); opcode[s] = 8'($urandom());
    n = 0; seen = 1'b0; busy_bad = 0;
    while (!seen && n < 100) begin
      @(negedge clk); n++;
      if (op_ready[s]) busy_bad++;
      seen = operation_done[s];
    end
    lat_exp = (op == 8'h07) ? 33 : dd[s] + 1;
    check("latency", n, lat_exp);
    check("ready_low", busy_bad, 0);
    held = exp_q.pop_front();
    check("result", result[s], held);
    check("op_error", op_error[s], ee);
`ifdef ALU_SEQ_FLAGS_EN
    check("flag_zero", flag_zero[s], er == 32'h0);
    check("flag_carry", flag_carry[s], ec);
    check("flag_overflow", flag_overflow[s], ev);
`endif
    @(negedge clk);
    check("done_one_cycle", operation_done[s], 0);
    check("ready_back", op_ready[s], 1);
    check("result_hold", result[s], held);
  endtask

  initial begin
    int cnt;
    logic [31:0] ra, rb;
    logic [7:0] rop;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      operand_a[i] = '0; operand_b[i] = '0; opcode[i] = '0; op_valid[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_ready", op_ready[0], 1);
    check("rst_done", operation_done[0], 0);
    check("rst_result", result[0], 0);
    check("rst_error", op_error[0], 0);
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (operation_done[0] || !op_ready[0]) cnt++; end
    check("idle_quiet", cnt, 0);

    do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 8'h00);
    check("add_wrap", result[0], 32'h0);
    do_op(0, 32'h0001_0003, 32'h0000_0005, 8'h07);
    check("mul_direct", result[0], 32'h0005_000F);
    do_op(0, 32'h1234_5678, 32'h9, 8'h2A);
    check("illegal_err", op_error[0], 1);
    do_op(0, 32'hF0F0_F0F0, 32'hFFFF_0000, 8'h04);
    check("xor_direct", result[0], 32'h0F0F_F0F0);
    do_op(0, 32'h0000_0005, 32'h0000_0007, 8'h01);
    do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 8'h00);
    do_op(1, 32'h0000_0001, 32'h0000_001F, 8'h05);
    check("shl_dd4", result[1], 32'h8000_0000);
    do_op(1, 32'h0000_0001, 32'h0000_0000, 8'h06);
    check("shr_zero", result[1], 32'h1);

    for (int i = 0; i < 40; i++) begin
      ra = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom();
      rb = (i % 5 == 0) ? 32'h8000_0000 : $urandom();
      rop = 8'($urandom_range(0, 8));
      if (rop == 8'h08) rop = 8'($urandom_range(8, 255));
      do_op(i % 4 == 3 ? 1 : 0, ra, rb, rop);
    end

    do_op(0, 32'h1, 32'h1, 8'h00);
    operand_a[0] = 32'h0001_0003; operand_b[0] = 32'h5; opcode[0] = 8'h07; op_valid[0] = 1'b1;
    @(posedge clk); #1;
    op_valid[0] = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_done", operation_done[0], 0);
    check("abort_result", result[0], 0);
    check("abort_error", op_error[0], 0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", op_ready[0], 1);
    cnt = 0;
    repeat (40) begin @(negedge clk); if (operation_done[0]) cnt++; end
    check("abort_no_done", cnt, 0);
    do_op(0, 32'd3, 32'd4, 8'h00);
    check("after_abort_add", result[0], 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
